exu_fpu_wb_ctl: RTL and testbench

Result-side responder for the FPU datapath. It accepts completed results from the FPU core on its out_valid/out_ready handshake and buffers them, with destination tag and exception status, in a small FIFO. It presents the results in order to the FP register-file write port on a valid/ready handshake. It also owns the sticky fflags accumulator, updated at write-back, which is the architectural commit point.

---
 rtl/exu_fpu_wb_ctl.sv | 96 +++++++++
 tb/tb_exu_fpu_wb_ctl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/exu_fpu_wb_ctl.sv
// FPU write-back controller: an in-order result FIFO between the FPU core and the FP
// register-file write port, plus the sticky fflags accumulator updated at commit.
module exu_fpu_wb_ctl #(
  parameter int DEPTH = 2,
  parameter int TAGW  = 5,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            flush_lower,
  input  logic            fpu_out_valid,
  output logic            fpu_out_ready,
  input  logic [31:0]     fpu_result,
  input  logic [4:0]      fpu_status,
  input  logic [TAGW-1:0] fpu_tag,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [TAGW-1:0] wb_rd,
  output logic [31:0]     wb_data,
  input  logic            fflags_wr_en,
  input  logic [4:0]      fflags_wr_data,
  output logic [4:0]      fflags,
  output logic [CNTW-1:0] wb_count
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]     data_mem   [DEPTH];
  logic [4:0]      status_mem [DEPTH];
  logic [TAGW-1:0] tag_mem    [DEPTH];

  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [CNTW-1:0] count;
  logic            push;
  logic            pop;
  logic [4:0]      fflags_next;

  // Explicit wrap so any DEPTH in 1..8 works, not just powers of two.
  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTRW'(DEPTH - 1)) return '0;
    else                       return p + PTRW'(1);
  endfunction

  // Ready and valid derive from registered occupancy only, so neither side
  // sees a combinational path from the other.
  assign fpu_out_ready = (count != CNTW'(DEPTH));
  assign wb_valid      = (count != '0);
  assign wb_count      = count;
  assign wb_rd         = tag_mem[rd_ptr];
  assign wb_data       = data_mem[rd_ptr];

  assign push = fpu_out_valid & fpu_out_ready & ~flush_lower;
  assign pop  = wb_valid & wb_ready & ~flush_lower;

  // A CSR write replaces the accumulator; the committing entry's status is
  // OR'd on top so neither source is lost in the same cycle.
  always_comb begin
    fflags_next = fflags_wr_en ? fflags_wr_data : fflags;
    if (pop) fflags_next = fflags_next | status_mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fflags <= '0;
    end else begin
      fflags <= fflags_next;
      if (flush_lower) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        case ({push, pop})
          2'b10:   count <= count + CNTW'(1);
          2'b01:   count <= count - CNTW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Entry payload carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr]   <= fpu_result;
      status_mem[wr_ptr] <= fpu_status;
      tag_mem[wr_ptr]    <= fpu_tag;
    end
  end

endmodule

// File: tb/tb_exu_fpu_wb_ctl.sv
// Directed vector bench for exu_fpu_wb_ctl (DEPTH=2): table of per-cycle inputs and
// post-edge expectations, followed by an asynchronous reset sequence.
module tb_exu_fpu_wb_ctl;

  localparam int DEPTH = 2;
  localparam int TAGW  = 5;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic            clk;
  logic            rst_l;
  logic            flush_lower;
  logic            fpu_out_valid;
  logic            fpu_out_ready;
  logic [31:0]     fpu_result;
  logic [4:0]      fpu_status;
  logic [TAGW-1:0] fpu_tag;
  logic            wb_valid;
  logic            wb_ready;
  logic [TAGW-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            fflags_wr_en;
  logic [4:0]      fflags_wr_data;
  logic [4:0]      fflags;
  logic [CNTW-1:0] wb_count;

  int checks;
  int failures;

  exu_fpu_wb_ctl #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .flush_lower   (flush_lower),
    .fpu_out_valid (fpu_out_valid),
    .fpu_out_ready (fpu_out_ready),
    .fpu_result    (fpu_result),
    .fpu_status    (fpu_status),
    .fpu_tag       (fpu_tag),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .fflags_wr_en  (fflags_wr_en),
    .fflags_wr_data(fflags_wr_data),
    .fflags        (fflags),
    .wb_count      (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] res;
    logic [4:0]  st;
    logic [4:0]  tag;
    logic        wr;
    logic        fl;
    logic        ce;
    logic [4:0]  cd;
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] edata;
    logic        erdy;
    logic [1:0]  ecnt;
    logic [4:0]  eff;
  } vec_t;

  vec_t tv[18];

  function automatic vec_t mk(
    input logic fv, input logic [31:0] res, input logic [4:0] st, input logic [4:0] tag,
    input logic wr, input logic fl, input logic ce, input logic [4:0] cd,
    input logic ev, input logic [4:0] erd, input logic [31:0] edata,
    input logic erdy, input logic [1:0] ecnt, input logic [4:0] eff);
    vec_t v;
    v.fv = fv; v.res = res; v.st = st; v.tag = tag;
    v.wr = wr; v.fl = fl; v.ce = ce; v.cd = cd;
    v.ev = ev; v.erd = erd; v.edata = edata;
    v.erdy = erdy; v.ecnt = ecnt; v.eff = eff;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fpu_out_valid  = 1'b0;
    fpu_result     = '0;
    fpu_status     = '0;
    fpu_tag        = '0;
    wb_ready       = 1'b0;
    flush_lower    = 1'b0;
    fflags_wr_en   = 1'b0;
    fflags_wr_data = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //          fv  result        st     tag    wr fl ce cd      ev rd     data          rdy cnt ff
    tv[0]  = mk(1, 32'h3F800000, 5'h01, 5'd5,  1, 0, 0, 5'h00,  1, 5'd5,  32'h3F800000, 1, 1, 5'h00);
    tv[1]  = mk(0, 32'h0,        5'h00, 5'd0,  1, 0, 0, 5'h00,  0, 5'd0,  32'h0,        1, 0, 5'h01);
    tv[2]  = mk(1, 32'h11111111, 5'h00, 5'd1,  0, 0, 0, 5'h00,  1, 5'd1,  32'h11111111, 1, 1, 5'h01);
    tv[3]  = mk(1, 32'h22222222, 5'h00, 5'd2,  0, 0, 0, 5'h00,  1, 5'd1,  32'h11111111, 0, 2, 5'h01);
    tv[4]  = mk(1, 32'h33333333, 5'h00, 5'd3,  0, 0, 0, 5'h00,  1, 5'd1,  32'h11111111, 0, 2, 5'h01);
    tv[5]  = mk(1, 32'h33333333, 5'h00, 5'd3,  1, 0, 0, 5'h00,  1, 5'd2,  32'h22222222, 1, 1, 5'h01);
    tv[6]  = mk(1, 32'h33333333, 5'h00, 5'd3,  1, 0, 0, 5'h00,  1, 5'd3,  32'h33333333, 1, 1, 5'h01);
    tv[7]  = mk(0, 32'h0,        5'h00, 5'd0,  1, 0, 1, 5'h00,  0, 5'd0,  32'h0,        1, 0, 5'h00);
    tv[8]  = mk(1, 32'h44444444, 5'h10, 5'd4,  0, 0, 0, 5'h00,  1, 5'd4,  32'h44444444, 1, 1, 5'h00);
    tv[9]  = mk(1, 32'h55555555, 5'h04, 5'd6,  0, 0, 0, 5'h00,  1, 5'd4,  32'h44444444, 0, 2, 5'h00);
    tv[10] = mk(1, 32'h99999999, 5'h08, 5'd9,  1, 1, 0, 5'h00,  0, 5'd0,  32'h0,        1, 0, 5'h00);
    tv[11] = mk(1, 32'h66666666, 5'h02, 5'd7,  0, 0, 1, 5'h1F,  1, 5'd7,  32'h66666666, 1, 1, 5'h1F);
    tv[12] = mk(0, 32'h0,        5'h00, 5'd0,  1, 0, 1, 5'h00,  0, 5'd0,  32'h0,        1, 0, 5'h02);
    tv[13] = mk(1, 32'hAAAAAAAA, 5'h01, 5'd10, 1, 1, 0, 5'h00,  0, 5'd0,  32'h0,        1, 0, 5'h02);
    tv[14] = mk(1, 32'h77777777, 5'h08, 5'd8,  0, 0, 0, 5'h00,  1, 5'd8,  32'h77777777, 1, 1, 5'h02);
    tv[15] = mk(1, 32'h88888888, 5'h01, 5'd11, 1, 1, 0, 5'h00,  0, 5'd0,  32'h0,        1, 0, 5'h02);
    tv[16] = mk(1, 32'hBBBBBBBB, 5'h00, 5'd12, 0, 0, 0, 5'h00,  1, 5'd12, 32'hBBBBBBBB, 1, 1, 5'h02);
    tv[17] = mk(0, 32'h0,        5'h00, 5'd0,  1, 0, 1, 5'h05,  0, 5'd0,  32'h0,        1, 0, 5'h05);

    idle_inputs();
    rst_l = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_l = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_ready", 32'(fpu_out_ready), 32'd1);
    check("rst_count", 32'(wb_count), 32'd0);
    check("rst_fflags", 32'(fflags), 32'd0);

    for (int i = 0; i < 18; i++) begin
      fpu_out_valid  = tv[i].fv;
      fpu_result     = tv[i].res;
      fpu_status     = tv[i].st;
      fpu_tag        = tv[i].tag;
      wb_ready       = tv[i].wr;
      flush_lower    = tv[i].fl;
      fflags_wr_en   = tv[i].ce;
      fflags_wr_data = tv[i].cd;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 32'(wb_valid), 32'(tv[i].ev));
      if (tv[i].ev) begin
        check($sformatf("v%0d_rd", i), 32'(wb_rd), 32'(tv[i].erd));
        check($sformatf("v%0d_data", i), wb_data, tv[i].edata);
      end
      check($sformatf("v%0d_ready", i), 32'(fpu_out_ready), 32'(tv[i].erdy));
      check($sformatf("v%0d_count", i), 32'(wb_count), 32'(tv[i].ecnt));
      check($sformatf("v%0d_fflags", i), 32'(fflags), 32'(tv[i].eff));
    end

    // Fill the buffer, then pull reset low between edges.
    idle_inputs();
    fpu_out_valid = 1'b1;
    fpu_result    = 32'hCCCCCCCC;
    fpu_tag       = 5'd13;
    fpu_status    = 5'h01;
    @(posedge clk);
    #1;
    fpu_result    = 32'hDDDDDDDD;
    fpu_tag       = 5'd14;
    @(posedge clk);
    #1;
    fpu_out_valid = 1'b0;
    wb_ready      = 1'b1;
    check("full_count", 32'(wb_count), 32'd2);
    check("full_ready", 32'(fpu_out_ready), 32'd0);
    #2 rst_l = 1'b0;
    #1;
    check("arst_valid", 32'(wb_valid), 32'd0);
    check("arst_ready", 32'(fpu_out_ready), 32'd1);
    check("arst_fflags", 32'(fflags), 32'd0);
    check("arst_count", 32'(wb_count), 32'd0);
    #2 rst_l = 1'b1;
    @(posedge clk);
    #1;
    check("post_arst_valid", 32'(wb_valid), 32'd0);
    check("post_arst_fflags", 32'(fflags), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
